// File: rtl/arcade_pkg.sv
// Shared command/reply byte codes and FSM encodings for the arcade output device.
package arcade_pkg;

  localparam int unsigned MAX_OUTPUTS = 8;
  localparam int unsigned BYTE_W      = 8;

  localparam logic [BYTE_W-1:0] CMD_SET_BASE = 8'h41;  // 'A'+n drives output n high
  localparam logic [BYTE_W-1:0] CMD_CLR_BASE = 8'h61;  // 'a'+n drives output n low
  localparam logic [BYTE_W-1:0] CMD_PULSE    = 8'h23;  // '#' idx dur
  localparam logic [BYTE_W-1:0] CMD_IDX_BASE = 8'h30;  // '0'+n selects pulse target
  localparam logic [BYTE_W-1:0] CMD_QUERY    = 8'h3D;  // '=' reports output bitmap
  localparam logic [BYTE_W-1:0] CMD_LF       = 8'h0A;
  localparam logic [BYTE_W-1:0] CMD_CR       = 8'h0D;
  localparam logic [BYTE_W-1:0] RSP_OK       = 8'h21;  // '!'
  localparam logic [BYTE_W-1:0] RSP_ERR      = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_IDX = 2'd1,
    ST_GET_DUR = 2'd2,
    ST_REPLY   = 2'd3
  } state_t;

  // True when b lies in [base, base+n).
  function automatic logic in_window(input logic [BYTE_W-1:0] b,
                                     input logic [BYTE_W-1:0] base,
                                     input int unsigned n);
    return (b >= base) && ((32'(b) - 32'(base)) < n);
  endfunction

endpackage

// File: rtl/output_pulse_timer.sv
// Per-output millisecond down-counter; load and cancel take priority over the beat.
module output_pulse_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             cancel,
  input  logic             beat,
  input  logic [CNT_W-1:0] duration,
  output logic             active,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (cancel) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= duration;
      active <= 1'b1;
    end else if (active && (count == '0)) begin
      active <= 1'b0;
    end else if (active && beat) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/arcade_output_device.sv
// Byte-command USB lamp/solenoid driver: set/clear/pulse/query with one-byte replies.
module arcade_output_device
  import arcade_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS      = 8,
  parameter int unsigned PARSE_TIMEOUT_MS = 10
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [10:0]            frame_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  input  logic                   usb_configured_i,
  output logic [NUM_OUTPUTS-1:0] outputs_o
);

  localparam int unsigned PT_W  = 16;
  localparam int unsigned DUR_W = 8;
  localparam int unsigned IDX_W = 3;

  logic                   frame_q;
  logic                   beat_1ms;
  logic                   unused_frame;
  state_t                 state_q, state_next;
  logic [IDX_W-1:0]       idx_q, idx_next;
  logic [PT_W-1:0]        ptimer_q, ptimer_next;
  logic [NUM_OUTPUTS-1:0] out_next, load_vec, cancel_vec, active_vec, zero_vec;
  logic [7:0]             data_next, reply;
  logic [7:0]             sel_set, sel_clr, sel_idx;
  logic                   ready_q, consume, queue;

  assign unused_frame = ^frame_i[10:1];
  assign out_ready_o  = ready_q & usb_configured_i;
  assign consume      = out_valid_i & out_ready_o;
  assign sel_set      = out_data_i - CMD_SET_BASE;
  assign sel_clr      = out_data_i - CMD_CLR_BASE;
  assign sel_idx      = out_data_i - CMD_IDX_BASE;

  // Frame-number bit 0 toggles once per ms; each toggle becomes a single beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_q  <= 1'b0;
      beat_1ms <= 1'b0;
    end else begin
      frame_q  <= frame_i[0];
      beat_1ms <= frame_i[0] ^ frame_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptimer_q   <= '0;
      outputs_o  <= '0;
      in_valid_o <= 1'b0;
      in_data_o  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_next;
      idx_q      <= idx_next;
      ptimer_q   <= ptimer_next;
      outputs_o  <= out_next;
      in_valid_o <= (state_next == ST_REPLY);
      in_data_o  <= data_next;
      ready_q    <= (state_next != ST_REPLY);
    end
  end

  always_comb begin
    state_next  = state_q;
    idx_next    = idx_q;
    ptimer_next = ptimer_q;
    out_next    = outputs_o;
    data_next   = in_data_o;
    load_vec    = '0;
    cancel_vec  = '0;
    queue       = 1'b0;
    reply       = RSP_ERR;

    // Expiring pulses drop first so a same-cycle command can override them.
    for (int unsigned n = 0; n < NUM_OUTPUTS; n++) begin
      if (active_vec[n] && zero_vec[n]) out_next[n] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        ptimer_next = '0;
        if (consume) begin
          if (in_window(out_data_i, CMD_SET_BASE, NUM_OUTPUTS)) begin
            for (int unsigned n = 0; n < NUM_OUTPUTS; n++) begin
              if (sel_set == 8'(n)) begin
                out_next[n]   = 1'b1;
                cancel_vec[n] = 1'b1;
              end
            end
            queue = 1'b1;
            reply = RSP_OK;
          end else if (in_window(out_data_i, CMD_CLR_BASE, NUM_OUTPUTS)) begin
            for (int unsigned n = 0; n < NUM_OUTPUTS; n++) begin
              if (sel_clr == 8'(n)) begin
                out_next[n]   = 1'b0;
                cancel_vec[n] = 1'b1;
              end
            end
            queue = 1'b1;
            reply = RSP_OK;
          end else if (out_data_i == CMD_QUERY) begin
            queue = 1'b1;
            reply = 8'(outputs_o);
          end else if (out_data_i == CMD_PULSE) begin
            state_next = ST_GET_IDX;
          end else if ((out_data_i != CMD_LF) && (out_data_i != CMD_CR)) begin
            queue = 1'b1;
          end
        end
      end

      ST_GET_IDX: begin
        if (consume) begin
          ptimer_next = '0;
          if (in_window(out_data_i, CMD_IDX_BASE, NUM_OUTPUTS)) begin
            idx_next   = IDX_W'(sel_idx);
            state_next = ST_GET_DUR;
          end else begin
            queue = 1'b1;
          end
        end else if (ptimer_q >= PT_W'(PARSE_TIMEOUT_MS)) begin
          state_next = ST_IDLE;
        end else if (beat_1ms) begin
          ptimer_next = ptimer_q + PT_W'(1);
        end
      end

      ST_GET_DUR: begin
        if (consume) begin
          ptimer_next = '0;
          queue       = 1'b1;
          if (out_data_i != '0) begin
            for (int unsigned n = 0; n < NUM_OUTPUTS; n++) begin
              if (idx_q == IDX_W'(n)) begin
                out_next[n] = 1'b1;
                load_vec[n] = 1'b1;
              end
            end
            reply = RSP_OK;
          end
        end else if (ptimer_q >= PT_W'(PARSE_TIMEOUT_MS)) begin
          state_next = ST_IDLE;
        end else if (beat_1ms) begin
          ptimer_next = ptimer_q + PT_W'(1);
        end
      end

      ST_REPLY: begin
        if (in_ready_i) begin
          state_next = ST_IDLE;
          data_next  = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    if (queue) begin
      state_next = ST_REPLY;
      data_next  = reply;
    end

    // Losing the USB configuration wipes everything back to a quiet idle.
    if (!usb_configured_i) begin
      state_next  = ST_IDLE;
      data_next   = '0;
      out_next    = '0;
      load_vec    = '0;
      cancel_vec  = '1;
      ptimer_next = '0;
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_timer
    output_pulse_timer #(.CNT_W(DUR_W)) u_timer (
      .clk      (clk_i),
      .rst_n    (rstn_i),
      .load     (load_vec[g]),
      .cancel   (cancel_vec[g]),
      .beat     (beat_1ms),
      .duration (out_data_i),
      .active   (active_vec[g]),
      .zero_c   (zero_vec[g])
    );
  end

endmodule

// File: tb/tb_arcade_output_device.sv
// Directed bench for arcade_output_device: set/clear/query/pulse/timeout/backpressure/disconnect/reset.
module tb_arcade_output_device;

  localparam int unsigned FRAME_CYC = 100;

  logic        clk;
  logic        rstn_i;
  logic [10:0] frame_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic        usb_configured_i;
  logic [7:0]  outputs_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  arcade_output_device #(.NUM_OUTPUTS(8), .PARSE_TIMEOUT_MS(10)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .frame_i          (frame_i),
    .out_data_i       (out_data_i),
    .out_valid_i      (out_valid_i),
    .out_ready_o      (out_ready_o),
    .in_data_o        (in_data_o),
    .in_valid_o       (in_valid_o),
    .in_ready_i       (in_ready_i),
    .usb_configured_i (usb_configured_i),
    .outputs_o        (outputs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One USB frame every FRAME_CYC cycles stands in for 1 ms.
  initial begin
    frame_i = '0;
    forever begin
      repeat (FRAME_CYC) @(negedge clk);
      frame_i = frame_i + 11'd1;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: observed no end, expected $finish before 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return #1 after the consuming edge.
  task automatic send(input logic [7:0] b, input string tag);
    int waited = 0;
    @(negedge clk);
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!out_ready_o) begin
      check({tag, " accept"}, 32'(out_ready_o), 32'd1);
      out_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    out_valid_i = 1'b0;
  endtask

  task automatic take_reply(input logic [7:0] exp, input string tag);
    int waited = 0;
    while (!in_valid_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " valid"}, 32'(in_valid_o), 32'd1);
    check({tag, " data"}, 32'(in_data_o), 32'(exp));
    @(negedge clk);
    in_ready_i = 1'b1;
    @(posedge clk);
    #1;
    in_ready_i = 1'b0;
    check({tag, " valid drop"}, 32'(in_valid_o), 32'd0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned hc;
    int waited;

    rstn_i           = 1'b0;
    usb_configured_i = 1'b1;
    out_valid_i      = 1'b0;
    out_data_i       = '0;
    in_ready_i       = 1'b0;

    repeat (3) @(negedge clk);
    check("rst outputs", 32'(outputs_o), 32'h00);
    check("rst in_valid", 32'(in_valid_o), 32'd0);
    check("rst in_data", 32'(in_data_o), 32'h00);
    check("rst out_ready", 32'(out_ready_o), 32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    check("idle out_ready", 32'(out_ready_o), 32'd1);

    // Set output 2
    send(8'h43, "set2");
    check("set2 outputs", 32'(outputs_o), 32'h04);
    check("set2 in_valid", 32'(in_valid_o), 32'd1);
    check("set2 in_data", 32'(in_data_o), 32'h21);
    check("set2 out_ready", 32'(out_ready_o), 32'd0);
    repeat (3) @(negedge clk);
    check("set2 held", 32'(in_valid_o), 32'd1);
    take_reply(8'h21, "set2");
    check("set2 data clear", 32'(in_data_o), 32'h00);
    check("set2 ready back", 32'(out_ready_o), 32'd1);

    send(8'h48, "set7");
    check("set7 outputs", 32'(outputs_o), 32'h84);
    take_reply(8'h21, "set7");

    // Clear output 2 with the host stalling the reply; a new byte waits meanwhile
    send(8'h63, "clr2");
    check("clr2 outputs", 32'(outputs_o), 32'h80);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      out_data_i  = 8'h41;
      out_valid_i = 1'b1;
      check("bp in_valid", 32'(in_valid_o), 32'd1);
      check("bp in_data", 32'(in_data_o), 32'h21);
      check("bp out_ready", 32'(out_ready_o), 32'd0);
    end
    @(negedge clk);
    out_valid_i = 1'b0;
    take_reply(8'h21, "clr2");
    check("bp no consume", 32'(outputs_o), 32'h80);

    send(8'h3D, "query1");
    take_reply(8'h80, "query1");

    send(8'h4A, "bad set");
    check("bad set outputs", 32'(outputs_o), 32'h80);
    take_reply(8'h3F, "bad set");

    send(8'h0A, "lf");
    check("lf silent", 32'(in_valid_o), 32'd0);
    check("lf ready", 32'(out_ready_o), 32'd1);

    send(8'h23, "hash");
    check("hash silent", 32'(in_valid_o), 32'd0);
    send(8'h39, "bad idx");
    take_reply(8'h3F, "bad idx");

    send(8'h23, "d0 hash");
    send(8'h31, "d0 idx");
    send(8'h00, "d0 dur");
    check("d0 outputs", 32'(outputs_o), 32'h80);
    take_reply(8'h3F, "d0");

    // 5 ms pulse on output 1
    send(8'h23, "p1 hash");
    send(8'h31, "p1 idx");
    send(8'h05, "p1 dur");
    t0 = cyc;
    check("p1 outputs high", 32'(outputs_o), 32'h82);
    take_reply(8'h21, "p1");
    waited = 0;
    while (outputs_o[1] && waited < 800) begin
      @(negedge clk);
      waited++;
    end
    hc = cyc - t0;
    check("p1 width in 400..505 cycles", 32'((hc >= 400) && (hc <= 505)), 32'd1);
    check("p1 outputs after", 32'(outputs_o), 32'h80);
    check("p1 single reply", 32'(in_valid_o), 32'd0);

    // A set command on a pulsing output cancels the pulse
    send(8'h23, "p3 hash");
    send(8'h33, "p3 idx");
    send(8'h05, "p3 dur");
    check("p3 outputs", 32'(outputs_o), 32'h88);
    take_reply(8'h21, "p3");
    send(8'h44, "set3");
    take_reply(8'h21, "set3");
    repeat (700) @(negedge clk);
    check("cancelled pulse stays", 32'(outputs_o), 32'h88);
    send(8'h64, "clr3");
    check("clr3 outputs", 32'(outputs_o), 32'h80);
    take_reply(8'h21, "clr3");

    // Parse timeout
    send(8'h23, "to hash");
    repeat (12 * FRAME_CYC) @(negedge clk);
    check("timeout silent", 32'(in_valid_o), 32'd0);
    send(8'h3D, "to query");
    take_reply(8'h80, "to query");

    // Disconnect during a pulse with a reply pending
    send(8'h23, "dc hash");
    send(8'h32, "dc idx");
    send(8'd50, "dc dur");
    take_reply(8'h21, "dc pulse");
    send(8'h3D, "dc query");
    check("dc pending data", 32'(in_data_o), 32'h84);
    @(negedge clk);
    usb_configured_i = 1'b0;
    @(posedge clk);
    #1;
    check("dc outputs", 32'(outputs_o), 32'h00);
    check("dc in_valid", 32'(in_valid_o), 32'd0);
    check("dc out_ready", 32'(out_ready_o), 32'd0);
    @(negedge clk);
    usb_configured_i = 1'b1;
    repeat (5) @(negedge clk);
    check("reconnect outputs", 32'(outputs_o), 32'h00);
    check("reconnect in_valid", 32'(in_valid_o), 32'd0);
    send(8'h3D, "reconnect query");
    take_reply(8'h00, "reconnect query");

    // Reset mid-pulse and mid-command
    send(8'h23, "rs hash");
    send(8'h30, "rs idx");
    send(8'd20, "rs dur");
    check("rs pulse outputs", 32'(outputs_o), 32'h01);
    take_reply(8'h21, "rs pulse");
    send(8'h23, "rs mid");
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check("rs outputs", 32'(outputs_o), 32'h00);
    check("rs in_valid", 32'(in_valid_o), 32'd0);
    check("rs out_ready", 32'(out_ready_o), 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    check("post rs outputs", 32'(outputs_o), 32'h00);
    send(8'h3D, "post rs query");
    take_reply(8'h00, "post rs query");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arcade_output_device.md
ARCADE_OUTPUT_DEVICE -- requirements
Module: arcade_output_device

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 8, number of driven outputs; legal range 1..8.
REQ-002 SHALL have parameter PARSE_TIMEOUT_MS, default 10, ms allowed between bytes of a multi-byte command.
REQ-003 Ports SHALL be exactly:
- clk_i  input  1  single clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- frame_i  input  11  USB frame number; bit 0 toggles about once per ms.
- out_data_i  input  8  host-to-device byte.
- out_valid_i  input  1  out_data_i valid; held stable until consumed.
- out_ready_o  output  1  byte consumed when out_valid_i and out_ready_o are both high.
- in_data_o  output  8  device-to-host reply byte.
- in_valid_o  output  1  in_data_o valid.
- in_ready_i  input  1  reply consumed when in_valid_o and in_ready_i are both high.
- usb_configured_i  input  1  USB link configured.
- outputs_o  output  NUM_OUTPUTS  driven lamp/solenoid lines.

Function
REQ-004 beat_1ms SHALL be a registered one-cycle pulse, asserted the cycle after frame_i[0] differs from its registered copy.
REQ-005 FSM states SHALL be IDLE, GET_IDX, GET_DUR, REPLY.
REQ-006 out_ready_o SHALL be high only in IDLE, GET_IDX or GET_DUR with usb_configured_i high.
REQ-007 In IDLE, byte 0x41+n (n<NUM_OUTPUTS) SHALL drive outputs_o[n] high, cancel its pulse, and queue reply 0x21 ('!').
REQ-008 In IDLE, byte 0x61+n (n<NUM_OUTPUTS) SHALL drive outputs_o[n] low, cancel its pulse, and queue reply 0x21.
REQ-009 In IDLE, byte 0x3D ('=') SHALL queue reply {zero-extended outputs_o} sampled in the consume cycle.
REQ-010 In IDLE, byte 0x23 ('#') SHALL move to GET_IDX with no reply.
REQ-011 In IDLE, bytes 0x0A and 0x0D SHALL be consumed silently.
REQ-012 In IDLE, any other byte, including 0x41+n or 0x61+n with n>=NUM_OUTPUTS, SHALL queue reply 0x3F ('?').
REQ-013 In GET_IDX, byte 0x30+n with n<NUM_OUTPUTS SHALL latch n and move to GET_DUR; any other byte SHALL queue 0x3F.
REQ-014 In GET_DUR, byte D with 1..255 SHALL drive outputs_o[n] high, load pulse counter[n]=D, and queue 0x21; D=0 SHALL queue 0x3F without changing outputs.
REQ-015 Queuing a reply SHALL enter REPLY with in_valid_o high and in_data_o set the cycle after the consuming handshake.
REQ-016 in_valid_o and in_data_o SHALL hold until in_ready_i is high, then go low next cycle with a return to IDLE.
REQ-017 outputs_o changes SHALL appear the cycle after the consuming handshake.
REQ-018 Each active pulse counter SHALL decrement on beat_1ms; the cycle after it reaches 0, its output SHALL go low and the pulse end.
REQ-019 A new pulse command on an active pulse SHALL reload the counter; pulse width SHALL be D-1 to D ms.
REQ-020 A beat_1ms coinciding with a reload SHALL be ignored for that output; the reload wins.
REQ-021 A parse timer SHALL count beat_1ms in GET_IDX/GET_DUR and reset on each consumed byte.
REQ-022 When the parse timer reaches PARSE_TIMEOUT_MS, the FSM SHALL return to IDLE silently.
REQ-023 While usb_configured_i is low: FSM SHALL be forced to IDLE, a pending reply dropped, in_valid_o low, all outputs and pulse counters cleared.

Reset
REQ-024 While rstn_i is low: outputs_o=0, in_valid_o=0, in_data_o=0x00, out_ready_o=0, FSM=IDLE, all counters=0, beat register=0.
REQ-025 Reset assertion mid-command or mid-pulse SHALL abort immediately with no reply and no glitch-high on outputs_o.

Structure
REQ-026 Command and reply byte constants (0x41, 0x61, 0x23, 0x30, 0x3D, 0x21, 0x3F) and FSM state encodings SHALL live in shared package arcade_pkg.
REQ-027 The per-output down-counter with load/cancel/beat inputs and an active output SHALL be sub-module output_pulse_timer, instantiated NUM_OUTPUTS times.

Verification
REQ-028 Set command: host sends 0x43 -> outputs_o[2]=1 next cycle; reply 0x21 held until in_ready_i.
REQ-029 Pulse command: host sends 0x23,0x31,0x05 with 1 ms beats -> outputs_o[1] high 4-5 ms then low; one 0x21 reply.
REQ-030 Invalid input: host sends 0x4A (NUM_OUTPUTS=8) -> reply 0x3F, outputs_o unchanged; host sends 0x23,0x39 -> 0x3F after second byte.
REQ-031 Timeout: host sends 0x23 then idles 12 frames -> FSM in IDLE, no reply; next 0x3D replies current bitmap.
REQ-032 Backpressure: in_ready_i held low 20 cycles after 0x61 -> in_valid_o and 0x21 stable, out_ready_o low throughout.
REQ-033 Disconnect: usb_configured_i drops during an active pulse and pending reply -> outputs_o=0 and in_valid_o=0 next cycle.
